// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU opcodes, FSM encoding
// and default widths.
package alu_share_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;

  localparam logic [OP_W_DEF-1:0] ADD_OP = 4'd0;
  localparam logic [OP_W_DEF-1:0] SUB_OP = 4'd1;
  localparam logic [OP_W_DEF-1:0] AND_OP = 4'd2;
  localparam logic [OP_W_DEF-1:0] OR_OP  = 4'd3;
  localparam logic [OP_W_DEF-1:0] XOR_OP = 4'd4;
  localparam logic [OP_W_DEF-1:0] SLL_OP = 4'd5;
  localparam logic [OP_W_DEF-1:0] SRL_OP = 4'd6;
  localparam logic [OP_W_DEF-1:0] SRA_OP = 4'd7;
  localparam logic [OP_W_DEF-1:0] SLT_OP = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response channels of the two ALU requesters. The requester side
// uses the master modport, the arbiter uses the slave modport.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
);

  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  rsp0_ready, rsp1_ready
  );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// The existing 32-bit combinational ALU. Opcodes above SLT yield zero;
// shifts use only the low five bits of op2 and SLT compares unsigned.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   ALUop,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] ALU_out
);

  logic [4:0] shamt_s;

  // Opcode decode and result selection.
  always_comb begin
    shamt_s = op2[4:0];
    ALU_out = {DATA_W{1'b0}};
    case (ALUop)
      ADD_OP:  ALU_out = op1 + op2;
      SUB_OP:  ALU_out = op1 - op2;
      AND_OP:  ALU_out = op1 & op2;
      OR_OP:   ALU_out = op1 | op2;
      XOR_OP:  ALU_out = op1 ^ op2;
      SLL_OP:  ALU_out = op1 << shamt_s;
      SRL_OP:  ALU_out = op1 >> shamt_s;
      SRA_OP:  ALU_out = DATA_W'($signed(op1) >>> shamt_s);
      SLT_OP:  ALU_out = {{(DATA_W-1){1'b0}}, (op1 < op2)};
      default: ALU_out = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Lends one combinational ALU to two valid/ready requesters with round-robin
// priority and a single operation in flight (IDLE -> EXEC -> RESP).
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OP_W      = OP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus,
  output logic               busy
);

  state_e            state_r;
  logic              prio_r;
  logic              own_r;
  logic [OP_W-1:0]   op_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] res_r;

  logic              grant_s;
  logic              grant_ok_s;
  logic              rsp_ready_own_s;
  logic [OP_W-1:0]   op_in_s;
  logic [DATA_W-1:0] a_in_s;
  logic [DATA_W-1:0] b_in_s;
  logic [DATA_W-1:0] alu_out_s;

  // Round-robin grant: the priority port wins if valid, otherwise the other one.
  always_comb begin
    grant_s    = prio_r;
    grant_ok_s = 1'b0;
    if ((prio_r ? bus.req1_valid : bus.req0_valid) == 1'b1) begin
      grant_s    = prio_r;
      grant_ok_s = 1'b1;
    end else if ((prio_r ? bus.req0_valid : bus.req1_valid) == 1'b1) begin
      grant_s    = ~prio_r;
      grant_ok_s = 1'b1;
    end else begin
      grant_s    = prio_r;
      grant_ok_s = 1'b0;
    end
    op_in_s         = grant_s ? bus.req1_op : bus.req0_op;
    a_in_s          = grant_s ? bus.req1_a  : bus.req0_a;
    b_in_s          = grant_s ? bus.req1_b  : bus.req0_b;
    rsp_ready_own_s = own_r ? bus.rsp1_ready : bus.rsp0_ready;
  end

  // Control FSM with priority bit, operand capture and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      prio_r  <= PRIO_INIT;
      own_r   <= 1'b0;
      op_r    <= {OP_W{1'b0}};
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      res_r   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_ok_s) begin
            own_r   <= grant_s;
            prio_r  <= ~grant_s;
            op_r    <= op_in_s;
            a_r     <= a_in_s;
            b_r     <= b_in_s;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          res_r   <= alu_out_s;
          state_r <= RESP;
        end
        RESP: begin
          if (rsp_ready_own_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  alu_share_arbiter_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .ALUop   (op_r),
    .op1     (a_r),
    .op2     (b_r),
    .ALU_out (alu_out_s)
  );

  // Output decode from registered state; everything is forced quiet while rst is high.
  always_comb begin
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.rsp0_valid  = 1'b0;
    bus.rsp1_valid  = 1'b0;
    bus.rsp0_result = {DATA_W{1'b0}};
    bus.rsp1_result = {DATA_W{1'b0}};
    busy            = 1'b0;
    if (!rst) begin
      bus.req0_ready  = (state_r == IDLE) && grant_ok_s && (grant_s == 1'b0);
      bus.req1_ready  = (state_r == IDLE) && grant_ok_s && (grant_s == 1'b1);
      bus.rsp0_valid  = (state_r == RESP) && (own_r == 1'b0);
      bus.rsp1_valid  = (state_r == RESP) && (own_r == 1'b1);
      bus.rsp0_result = res_r;
      bus.rsp1_result = res_r;
      busy            = (state_r != IDLE);
    end else begin
      busy            = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter with an arithmetic
// reference model and a round-robin priority model.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   prio_m = 0;

  alu_share_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

  alu_share_arbiter #(.PRIO_INIT(1'b0), .DATA_W(32), .OP_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    int          sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a + ~b + 32'd1;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: begin ext = {32'd0, a} << sh; return ext[31:0]; end
      4'd6: begin ext = {32'd0, a} >> sh; return ext[31:0]; end
      4'd7: begin ext = {{32{a[31]}}, a} >> sh; return ext[31:0]; end
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rspv(input int p);
    return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [31:0] res(input int p);
    return (p == 0) ? bus.rsp0_result : bus.rsp1_result;
  endfunction

  task automatic drive(input int p, input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic set_rr(input int p, input logic v);
    if (p == 0) bus.rsp0_ready = v;
    else        bus.rsp1_ready = v;
  endtask

  // One full transaction for port p; the port must be granted in the current IDLE cycle.
  task automatic serve(input int p, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int hold);
    drive(p, 1'b1, op, a, b);
    #1;
    chk1("grant", rdy(p), 1'b1);
    chk1("grant_exclusive", rdy(1 - p), 1'b0);
    tick();
    hs_cyc = cyc;
    drive(p, 1'b0, 4'd0, 32'd0, 32'd0);
    chk1("exec_busy", busy, 1'b1);
    chk1("exec_rsp_valid", rspv(p), 1'b0);
    chk1("exec_other_ready", rdy(1 - p), 1'b0);
    tick();
    chk1("rsp_valid", rspv(p), 1'b1);
    chk1("rsp_other_valid", rspv(1 - p), 1'b0);
    chk32("rsp_result", res(p), exp_res);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk1("hold_valid", rspv(p), 1'b1);
      chk32("hold_result", res(p), exp_res);
      chk1("hold_busy", busy, 1'b1);
      chk1("hold_other_ready", rdy(1 - p), 1'b0);
    end
    set_rr(p, 1'b1);
    tick();
    set_rr(p, 1'b0);
    chk1("done_valid", rspv(p), 1'b0);
    chk1("done_busy", busy, 1'b0);
    prio_m = 1 - p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    prio_m = 0;
  endtask

  initial begin
    int h;
    int w;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;

    // Reset: ready stays low while rst is high even with a request pending.
    rst = 1'b1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    drive(0, 1'b1, 4'd0, 32'd1, 32'd1);
    drive(1, 1'b1, 4'd0, 32'd1, 32'd1);
    tick();
    tick();
    #1;
    chk1("rst_req0_ready", bus.req0_ready, 1'b0);
    chk1("rst_req1_ready", bus.req1_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    chk32("rst_rsp0_result", bus.rsp0_result, 32'd0);
    chk32("rst_rsp1_result", bus.rsp1_result, 32'd0);
    do_reset();

    // Lone ADD on port 0.
    serve(0, 4'd0, 32'd5, 32'd7, 32'd12, 0);

    // Simultaneous requests after reset; port 0 holds its response for 4 cycles.
    do_reset();
    drive(0, 1'b1, 4'd1, 32'd10, 32'd3);
    drive(1, 1'b1, 4'd4, 32'h0000_00F0, 32'h0000_000F);
    #1;
    chk1("both_req0_ready", bus.req0_ready, 1'b1);
    chk1("both_req1_ready", bus.req1_ready, 1'b0);
    serve(0, 4'd1, 32'd10, 32'd3, 32'd7, 4);
    serve(1, 4'd4, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0);

    // Shift and compare corner cases.
    serve(0, 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
    serve(1, 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    serve(0, 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    serve(0, 4'd5, 32'd1, 32'h0000_0025, 32'h0000_0020, 0);

    // Reset while in EXEC discards the operation.
    drive(0, 1'b1, 4'd0, 32'd1, 32'd2);
    #1;
    tick();
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk1("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    tick();
    rst = 1'b0;
    prio_m = 0;
    #1;
    chk1("post_rst_busy", busy, 1'b0);
    chk32("post_rst_result", bus.rsp0_result, 32'd0);
    bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk1("discard_rsp0_valid", bus.rsp0_valid, 1'b0);
      chk1("discard_rsp1_valid", bus.rsp1_valid, 1'b0);
      chk1("discard_busy", busy, 1'b0);
      tick();
    end
    bus.rsp0_ready = 1'b0;

    // Undefined opcode, then back-to-back port 0 issue interval.
    serve(0, 4'hF, 32'd1, 32'd1, 32'd0, 0);
    h = hs_cyc;
    serve(0, 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);
    chk32("issue_gap", 32'(hs_cyc - h), 32'd3);
    h = hs_cyc;
    serve(0, 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
    chk32("issue_gap", 32'(hs_cyc - h), 32'd3);

    // Randomized traffic, with contention resolved by the priority model.
    for (int n = 0; n < 40; n++) begin
      op0 = 4'($urandom_range(0, 15));
      op1 = 4'($urandom_range(0, 15));
      a0  = $urandom;
      a1  = $urandom;
      b0  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b1  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        w = prio_m;
        drive(1 - w, 1'b1, op1, a1, b1);
        serve(w, op0, a0, b0, ref_alu(op0, a0, b0), int'($urandom_range(0, 2)));
        serve(1 - w, op1, a1, b1, ref_alu(op1, a1, b1), int'($urandom_range(0, 2)));
      end else begin
        w = int'($urandom_range(0, 1));
        serve(w, op0, a0, b0, ref_alu(op0, a0, b0), int'($urandom_range(0, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
